conv_accumulator: RTL
=====================

Name: conv_accumulator

Overview:
- Stage directly downstream of the multiplier array; consumes one registered product per cycle and sums one kernel window of products plus a bias.
- Applies a right shift and unsigned saturation to 8 bits; the result is the next-layer neuron input.
- Presents the result through a one-entry valid/ready output register.
- Back-pressures upstream via in_ready. The controller gates multi_en with in_ready.

Parameters:
- PRODUCT_BIT_WIDTH, 20, width of incoming unsigned product.
- OUTPUT_BIT_WIDTH, 8, width of saturated result.
- LEN_BIT_WIDTH, 8, width of acc_len; max window 2^LEN_BIT_WIDTH-1 products.
- ACC_BIT_WIDTH, PRODUCT_BIT_WIDTH+LEN_BIT_WIDTH+1, accumulator width; overflow impossible by construction.

Ports:
- clk  in  1  clock, rising edge.
- layer_reset_n  in  1  asynchronous active-low reset.
- product  in  PRODUCT_BIT_WIDTH  unsigned product from multiplier.
- product_valid  in  1  product holds a real window term this cycle.
- in_ready  out  1  stage accepts product this cycle.
- acc_len  in  LEN_BIT_WIDTH  products per window; sampled on first accepted product of a window.
- bias  in  PRODUCT_BIT_WIDTH  unsigned bias; sampled with acc_len.
- out_shift  in  5  right-shift amount; sampled with acc_len.
- result  out  OUTPUT_BIT_WIDTH  saturated window result.
- result_valid  out  1  result holds an unconsumed value.
- result_ready  in  1  consumer takes result when result_valid & result_ready.
- busy  out  1  high in ST_ACC, i.e. a window is partially summed.

Behaviour:
- Reset, asynchronous and active-low:
  - state=ST_IDLE; acc=0; cnt=0; result=0; result_valid=0; busy=0.
  - in_ready follows its combinational rule: in_ready=1 after reset.
- in_ready = ~result_valid | result_ready (combinational). Accept = product_valid & in_ready. Product is ignored when not accepted; upstream holds it.
- acc_len=0 is treated as 1.
- FSM states: ST_IDLE, ST_ACC.
- ST_IDLE, on accept:
  - Latch len=max(acc_len,1), bias_r=bias, shift_r=out_shift.
  - If len==1: finish immediately with sum=bias+product; stay in ST_IDLE.
  - Else: acc=bias+product, cnt=1, go to ST_ACC.
- ST_ACC, on accept:
  - If cnt==len-1: finish with sum=acc+product; go to ST_IDLE; cnt=0.
  - Else: acc+=product; cnt+=1.
  - No accept means hold.
- Finish, in the same edge:
  - result <= (sum>>shift_r) > 2^OUTPUT_BIT_WIDTH-1 ? all ones : (sum>>shift_r)[OUTPUT_BIT_WIDTH-1:0].
  - result_valid <= 1.
  - Latency: result_valid is high one cycle after the last product is accepted.
- Output handshake:
  - result_valid & result_ready with no finish in that cycle: result_valid <= 0; result unchanged.
  - Finish and handshake in the same cycle: new result loaded, result_valid stays 1, no bubble.
  - result_valid & ~result_ready: in_ready=0, so no accept; acc and cnt frozen. Accumulation does not overlap a stalled output, which keeps the design simple.
- Back-to-back windows with result_ready=1 sustain one product per cycle with no bubbles.
- Mid-window reset: partial sum discarded; the next accepted product starts a new window.
- acc_len, bias and out_shift changes mid-window have no effect until the next window.
- result_valid must not drop without a handshake. result must stay stable while result_valid & ~result_ready.

Decomposition:
- Shared package cnn_pkg holds:
  - constants PRODUCT_BIT_WIDTH, OUTPUT_BIT_WIDTH, LEN_BIT_WIDTH;
  - the state encoding ST_IDLE/ST_ACC;
  - a saturating-shift function (sum, shift) -> OUTPUT_BIT_WIDTH.
- One natural sub-module: shift_saturate, combinational, reused by the later pooling stage.
- FSM, counter and output register stay in conv_accumulator.

Test Plan:
- Basic window: acc_len=9, bias=0, shift=2, nine products of 100, result_ready=1 -> one result_valid pulse one cycle after the 9th accept, result=225 (900>>2).
- Bias and saturation: acc_len=4, bias=10, shift=0, products 0xFFFFF x4 -> result=255. Then acc_len=1, bias=3, product=4, shift=0 -> result=7.
- Back-pressure:
  - Stimulus: hold result_ready=0 after window 1 completes (acc_len=2, products 50,50, shift 0 -> 100); stream window 2 (products 7,8).
  - Required: in_ready=0 and products held, with no loss and no duplication, while result=100 stays stable.
  - Then raise result_ready: result 100 taken, window 2 completes, result=15.
- Back-to-back: acc_len=3, shift 0, continuous products 1..9, result_ready=1 -> results 6, 15, 24 on consecutive windows, in_ready constantly 1.
- Reset mid-window: acc_len=4, two products of 200 accepted, assert layer_reset_n low for 1 cycle -> all outputs 0, busy=0. A fresh window of 4 products of 1 (shift 0) -> result=4.
- acc_len=0: product=9, bias=0, shift=0 -> treated as length 1, result=9 next cycle.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants, FSM encoding and helpers.
// Used by the accumulator and the downstream pooling stage.
package cnn_pkg;

  localparam int PRODUCT_BIT_WIDTH = 20;
  localparam int OUTPUT_BIT_WIDTH  = 8;
  localparam int LEN_BIT_WIDTH     = 8;
  localparam int ACC_BIT_WIDTH     =
    PRODUCT_BIT_WIDTH + LEN_BIT_WIDTH + 1;
  localparam int SHIFT_BIT_WIDTH   = 5;

  typedef logic [PRODUCT_BIT_WIDTH-1:0] prod_t;
  typedef logic [OUTPUT_BIT_WIDTH-1:0]  out_t;
  typedef logic [LEN_BIT_WIDTH-1:0]     len_t;
  typedef logic [ACC_BIT_WIDTH-1:0]     acc_t;
  typedef logic [SHIFT_BIT_WIDTH-1:0]   shift_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  // Right shift, then clamp to the unsigned output range.
  function automatic out_t sat_shift(
    input acc_t   sum,
    input shift_t shift
  );
    acc_t s;
    s = sum >> shift;
    if (|s[ACC_BIT_WIDTH-1:OUTPUT_BIT_WIDTH])
      return '1;
    return s[OUTPUT_BIT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/conv_accumulator_if.sv
// Product-in / result-out bundle of the conv accumulator.
// master = controller side, slave = accumulator side.
interface conv_accumulator_if;
  import cnn_pkg::*;

  prod_t  product;
  logic   product_valid;
  logic   in_ready;
  len_t   acc_len;
  prod_t  bias;
  shift_t out_shift;
  out_t   result;
  logic   result_valid;
  logic   result_ready;
  logic   busy;

  modport master (
    output product, product_valid,
    output acc_len, bias, out_shift,
    output result_ready,
    input  in_ready, result,
    input  result_valid, busy
  );

  modport slave (
    input  product, product_valid,
    input  acc_len, bias, out_shift,
    input  result_ready,
    output in_ready, result,
    output result_valid, busy
  );

endinterface

// File: rtl/shift_saturate.sv
// Combinational shift-and-saturate of a wide sum.
// Shared with the pooling stage.
module shift_saturate
  import cnn_pkg::*;
(
  input  acc_t   sum,
  input  shift_t shift,
  output out_t   result
);

  assign result = sat_shift(sum, shift);

endmodule

// File: rtl/conv_accumulator.sv
// Sums one kernel window of products plus bias, then
// shifts/saturates into a one-entry valid/ready register.
module conv_accumulator
  import cnn_pkg::*;
(
  input logic clk,
  input logic layer_reset_n,
  conv_accumulator_if.slave bus
);

  logic [0:0] state;
  acc_t       acc;
  len_t       cnt;
  len_t       len_r;
  shift_t     shift_r;
  out_t       result_r;
  logic       valid_r;

  logic       in_ready;
  logic       accept;
  logic       last;
  logic       finish;
  len_t       len_in;
  acc_t       base;
  acc_t       sum;
  shift_t     sh;
  out_t       sat;

  assign in_ready = ~valid_r | bus.result_ready;
  assign accept   = bus.product_valid & in_ready;
  assign finish   = accept & last;

  assign len_in = (bus.acc_len == '0) ?
                  LEN_BIT_WIDTH'(1) : bus.acc_len;

  // Window start uses live bias/shift; later terms use latched ones.
  always_comb begin
    base = '0;
    sh   = shift_r;
    last = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): begin
        base = acc_t'(bus.bias);
        sh   = bus.out_shift;
        last = (len_in == LEN_BIT_WIDTH'(1));
      end
      (state == ST_ACC): begin
        base = acc;
        last = (cnt == len_r - LEN_BIT_WIDTH'(1));
      end
    endcase
    sum = base + acc_t'(bus.product);
  end

  shift_saturate u_sat (
    .sum    (sum),
    .shift  (sh),
    .result (sat)
  );

  // Window FSM, running sum and term counter.
  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      len_r   <= '0;
      shift_r <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        len_r   <= len_in;
        shift_r <= bus.out_shift;
      end
      if (finish) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        state <= ST_ACC;
        acc   <= sum;
        cnt   <= cnt + LEN_BIT_WIDTH'(1);
      end
    end
  end

  // One-entry output register; reload on finish beats a drain.
  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      result_r <= '0;
      valid_r  <= 1'b0;
    end else if (finish) begin
      result_r <= sat;
      valid_r  <= 1'b1;
    end else if (valid_r && bus.result_ready) begin
      valid_r  <= 1'b0;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.result       = result_r;
  assign bus.result_valid = valid_r;
  assign bus.busy         = (state == ST_ACC);

endmodule
